rom_bus_responder: RTL
======================

# rom_bus_responder

ROM-side responder for the CPU's 4-bit multiplexed instruction bus, modelled on a 4001-class ROM chip. It tracks the eight-phase microcycle (A1..X3) from the CPU's `sync` strobe and captures the 12-bit fetch address during A1/A2/A3. When its chip ID matches, it drives the instruction byte as two nibbles during M1/M2. It also serves the SRC/WRR/RDR I/O-port protocol. Several instances, one per chip ID, share a single bus.

## Interface

**Parameters**
- `CHIP_ID`, default 4'd0: this chip's ID; selects on address high nibble and on the SRC chip nibble.
- `ADDR_W`, default 8: bytes per chip, as 2^ADDR_W. Fixed at 8 (256 × 8 array).

**Ports** (clock and reset first)
- `clk`  in  1: single system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `sync`  in  1: high during X3; the next cycle is A1.
- `cmRom`  in  1: CPU command line. At M2 it marks an I/O instruction; at X2 it marks SRC.
- `busIn`  in  4: nibble currently on the shared bus.
- `busOut`  out  4: nibble this chip drives.
- `busOe`  out  1: drive enable. Only one chip may assert it per cycle.
- `ioIn`  in  4: external input port, returned by RDR.
- `ioOut`  out  4: external output port, written by WRR.
- `progWe`  in  1: program-load write strobe (bench/boot loader).
- `progAddr`  in  8: program-load byte address.
- `progData`  in  8: program-load byte, OPR in [7:4], OPA in [3:0].
- `srcSel`  out  1: this chip is currently selected by the last SRC.
- `phase`  out  3: current microcycle (0=A1 … 7=X3), for debug.

## Operation

**Phase counter**
- Registered, 0..7; reset value 7 (X3).
- If `sync` = 1: next phase = 0.
- Otherwise phase increments, wrapping 7 → 0.
- `sync` asserted in any phase other than 7 still forces A1 next cycle (resynchronisation). Any in-flight fetch or I/O is abandoned and `busOe` drops.

**Address capture** (registered at the end of the phase)
- A1: `addrLow ← busIn`.
- A2: `addrMid ← busIn`.
- A3: `fetchHit ← (busIn == CHIP_ID)`, and `romByte ← mem[{addrMid, addrLow}]`.

**Instruction tracking**
- Applies to every fetch, including fetches served by another chip.
- End of M1: `oprSeen ← busIn`.
- End of M2: `ioPending ← cmRom & (oprSeen == 4'hE)`; `ioOpa ← busIn`.
- `ioPending` clears at the end of X3.

**SRC**
- End of X2 with `cmRom` = 1 and no `ioPending`: `srcSel ← (busIn == CHIP_ID)`.
- `srcSel` holds until the next SRC or reset.

**WRR** (`ioOpa` = 4'h2)
- End of X2 with `ioPending` & `srcSel`: `ioOut ← busIn` (ACC on the bus).

**RDR** (`ioOpa` = 4'hA)
- With `ioPending` & `srcSel`, drive `busOut ← ioIn` with `busOe` = 1 for the whole X2 cycle.
- Any other `ioOpa` is ignored.

**Program load**
- `progWe` writes `mem[progAddr] ← progData` on the clock edge, in any phase.
- A same-cycle write and A3 read of the same address returns the old byte.

## Timing

- All outputs are registered. Reset values:
  - `busOut` = 0, `busOe` = 0, `ioOut` = 0, `srcSel` = 0, `phase` = 7.
  - Internal `fetchHit` = 0, `ioPending` = 0.
- Fetch drive:
  - Edge ending A3: `busOe ← fetchHitNext`, `busOut ← romByte[7:4]` (OPR), valid throughout M1.
  - Edge ending M1: `busOut ← romByte[3:0]` (OPA), valid throughout M2.
  - Edge ending M2: `busOe ← 0`.
- RDR drive:
  - Edge ending X1: `busOe`/`busOut` set.
  - Edge ending X2: `busOe ← 0`.
- Latency from A3 address nibble to first data nibble on the bus: 1 clock.
- `busOe` is never high in A1–A3, X1 or X3.
- Address wrap is not handled here; the CPU owns PC increment. Address 0xFF on chip N is followed by the CPU's next address.
- Reset mid-fetch or mid-I/O: outputs return to reset values immediately (asynchronous); `mem` contents are preserved.

## Test plan

1. Load `mem[0x34]` = 0xD7 with `CHIP_ID` = 2. Bus A1=4, A2=3, A3=2 → M1 `busOut` = 0xD with `busOe` = 1; M2 `busOut` = 0x7 with `busOe` = 1; X1 `busOe` = 0.
2. Same fetch with A3 = 5 → `busOe` stays 0 for all eight phases.
3. SRC: `cmRom` = 1 at X2, bus = 2 → `srcSel` = 1. Next instruction: M1 bus 0xE, M2 bus 0x2 with `cmRom` = 1, X2 bus 0x9 → `ioOut` = 0x9 after X2.
4. With `srcSel` = 1 and `ioIn` = 0x6: an RDR instruction (M1 bus 0xE, M2 bus 0xA, `cmRom` at M2) → X2 `busOut` = 0x6 with `busOe` = 1. Repeating after an SRC to chip 3 → `busOe` = 0, `ioOut` unchanged.
5. Assert `sync` during M1 of a hit fetch → `busOe` = 0 next cycle and `phase` = 0.
6. Assert `rst` during M2 of a hit fetch → `busOe` = 0 and `srcSel` = 0 immediately. After release, a fetch of the same address returns the same byte.

Source files
------------

// File: rtl/rom_bus_responder.sv
// ---------------------------------------------------------------------------
// rom_bus_responder
//
// ROM-side responder for the CPU's 4-bit multiplexed instruction bus, in the
// style of a 4001-class ROM. It follows the eight-phase microcycle
// (A1 A2 A3 M1 M2 X1 X2 X3) using the CPU's sync strobe. During A1..A3 it
// captures the 12-bit fetch address. When the high address nibble matches
// CHIP_ID, it drives the addressed instruction byte as two nibbles in M1/M2.
// It also implements the SRC / WRR / RDR I/O-port protocol. Several instances,
// one per chip ID, share a single bus.
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset (mem contents are kept)
//   sync      high during X3; forces A1 on the next cycle from any phase
//   cmRom     CPU command line: I/O marker at M2, SRC marker at X2
//   busIn     nibble currently on the shared bus
//   busOut    nibble driven by this chip (0 when not driving)
//   busOe     drive enable for busOut
//   ioIn      external input port, returned by RDR
//   ioOut     external output port, written by WRR
//   progWe    program-load write strobe
//   progAddr  program-load byte address
//   progData  program-load byte (OPR in [7:4], OPA in [3:0])
//   srcSel    this chip was selected by the most recent SRC
//   phase     current microcycle phase, 0 = A1 ... 7 = X3
// ---------------------------------------------------------------------------
module rom_bus_responder #(
   parameter logic [3:0] CHIP_ID = 4'd0,
   parameter int         ADDR_W  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sync,
   input  logic       cmRom,
   input  logic [3:0] busIn,
   output logic [3:0] busOut,
   output logic       busOe,
   input  logic [3:0] ioIn,
   output logic [3:0] ioOut,
   input  logic       progWe,
   input  logic [7:0] progAddr,
   input  logic [7:0] progData,
   output logic       srcSel,
   output logic [2:0] phase
);

   // Instruction decode constants
   localparam logic [3:0] OPR_IO  = 4'hE;   // I/O-group opcode nibble
   localparam logic [3:0] OPA_WRR = 4'h2;   // write ROM port
   localparam logic [3:0] OPA_RDR = 4'hA;   // read ROM port

   typedef enum logic [2:0] {
      PH_A1 = 3'd0,
      PH_A2 = 3'd1,
      PH_A3 = 3'd2,
      PH_M1 = 3'd3,
      PH_M2 = 3'd4,
      PH_X1 = 3'd5,
      PH_X2 = 3'd6,
      PH_X3 = 3'd7
   } phase_t;

   // What this chip puts on the bus during the current cycle.
   typedef enum logic [1:0] {
      DRV_NONE = 2'd0,
      DRV_OPR  = 2'd1,
      DRV_OPA  = 2'd2,
      DRV_IO   = 2'd3
   } drive_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   phase_t     phaseReg,     phaseNext;
   drive_t     driveReg,     driveNext;
   logic [3:0] addrLowReg,   addrLowNext;
   logic [3:0] addrMidReg,   addrMidNext;
   logic       fetchHitReg,  fetchHitNext;
   logic [3:0] oprSeenReg,   oprSeenNext;
   logic       ioPendingReg, ioPendingNext;
   logic [3:0] ioOpaReg,     ioOpaNext;
   logic       srcSelReg,    srcSelNext;
   logic [3:0] ioOutReg,     ioOutNext;
   logic [3:0] ioDriveReg,   ioDriveNext;

   // Program store; romByteReg is its registered read port.
   logic [7:0] mem [0:(2**ADDR_W)-1];
   logic [7:0] romByteReg;
   logic [7:0] romAddr;

   // An I/O instruction addressed to this chip's port.
   logic       ioActive;

   assign romAddr  = {addrMidReg, addrLowReg};
   assign ioActive = ioPendingReg & srcSelReg;

   // ------------------------------------------------------------------
   // Phase counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phaseReg <= PH_X3;
      end else begin
         phaseReg <= phaseNext;
      end
   end

   always_comb begin
      phaseNext = phaseReg;
      if (sync) begin
         // Resynchronise from any phase, not only X3.
         phaseNext = PH_A1;
      end else begin
         // 3-bit increment wraps X3 -> A1 naturally.
         phaseNext = phase_t'(phaseReg + 3'd1);
      end
   end

   // ------------------------------------------------------------------
   // Bus tracking, fetch drive and I/O protocol
   // ------------------------------------------------------------------
   always_comb begin
      driveNext     = driveReg;
      addrLowNext   = addrLowReg;
      addrMidNext   = addrMidReg;
      fetchHitNext  = fetchHitReg;
      oprSeenNext   = oprSeenReg;
      ioPendingNext = ioPendingReg;
      ioOpaNext     = ioOpaReg;
      srcSelNext    = srcSelReg;
      ioOutNext     = ioOutReg;
      ioDriveNext   = ioDriveReg;

      if (sync) begin
         // sync abandons whatever fetch or I/O was in flight. In the
         // normal X3 case this is also where ioPending would clear.
         driveNext     = DRV_NONE;
         fetchHitNext  = 1'b0;
         ioPendingNext = 1'b0;
      end else begin
         case (phaseReg)
            PH_A1: begin
               addrLowNext = busIn;
            end
            PH_A2: begin
               addrMidNext = busIn;
            end
            PH_A3: begin
               fetchHitNext = (busIn == CHIP_ID);
               // The byte is read on this same edge, so the OPR nibble is
               // on the bus one clock after the chip nibble.
               driveNext    = fetchHitNext ? DRV_OPR : DRV_NONE;
            end
            PH_M1: begin
               // Every chip watches the instruction, including the ones
               // that did not serve the fetch.
               oprSeenNext = busIn;
               driveNext   = fetchHitReg ? DRV_OPA : DRV_NONE;
            end
            PH_M2: begin
               ioPendingNext = cmRom & (oprSeenReg == OPR_IO);
               ioOpaNext     = busIn;
               driveNext     = DRV_NONE;
            end
            PH_X1: begin
               // ioIn is sampled here and held for the whole X2 cycle.
               if (ioActive && (ioOpaReg == OPA_RDR)) begin
                  driveNext   = DRV_IO;
                  ioDriveNext = ioIn;
               end else begin
                  driveNext   = DRV_NONE;
               end
            end
            PH_X2: begin
               driveNext = DRV_NONE;
               // While an I/O instruction is pending, cmRom at X2 is not SRC.
               if (cmRom && !ioPendingReg) begin
                  srcSelNext = (busIn == CHIP_ID);
               end
               if (ioActive && (ioOpaReg == OPA_WRR)) begin
                  ioOutNext = busIn;
               end
            end
            PH_X3: begin
               ioPendingNext = 1'b0;
               driveNext     = DRV_NONE;
            end
            default: begin
               driveNext = DRV_NONE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         driveReg     <= DRV_NONE;
         addrLowReg   <= 4'h0;
         addrMidReg   <= 4'h0;
         fetchHitReg  <= 1'b0;
         oprSeenReg   <= 4'h0;
         ioPendingReg <= 1'b0;
         ioOpaReg     <= 4'h0;
         srcSelReg    <= 1'b0;
         ioOutReg     <= 4'h0;
         ioDriveReg   <= 4'h0;
      end else begin
         driveReg     <= driveNext;
         addrLowReg   <= addrLowNext;
         addrMidReg   <= addrMidNext;
         fetchHitReg  <= fetchHitNext;
         oprSeenReg   <= oprSeenNext;
         ioPendingReg <= ioPendingNext;
         ioOpaReg     <= ioOpaNext;
         srcSelReg    <= srcSelNext;
         ioOutReg     <= ioOutNext;
         ioDriveReg   <= ioDriveNext;
      end
   end

   // ------------------------------------------------------------------
   // Program store. It has no reset, so its contents survive rst. A load
   // to the address being read at A3 returns the old byte, because the
   // read samples the array before the write takes effect.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (progWe) begin
         mem[progAddr] <= progData;
      end
      if (phaseReg == PH_A3) begin
         romByteReg <= mem[romAddr];
      end
   end

   // ------------------------------------------------------------------
   // Outputs. busOut is chosen only from registered state (driveReg,
   // romByteReg, ioDriveReg), so there is no path from any input to the
   // bus. It reads 0 whenever the chip is not driving.
   // ------------------------------------------------------------------
   always_comb begin
      busOut = 4'h0;
      case (driveReg)
         DRV_OPR:  busOut = romByteReg[7:4];
         DRV_OPA:  busOut = romByteReg[3:0];
         DRV_IO:   busOut = ioDriveReg;
         default:  busOut = 4'h0;
      endcase
   end

   assign busOe  = (driveReg != DRV_NONE);
   assign ioOut  = ioOutReg;
   assign srcSel = srcSelReg;
   assign phase  = phaseReg;

endmodule
